bcd_convertidor_secuencial: RTL



---
 rtl/bcd_convertidor_secuencial.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bcd_convertidor_secuencial.sv
// Multi-channel binary-to-BCD converter built on one time-multiplexed double-dabble engine.
// Define BCD_SATURATE_EN to report all nines instead of all zeros for out-of-range channels.
module bcd_convertidor_secuencial #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 2,
  parameter int CHANNELS  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CHANNELS*BIN_WIDTH-1:0] bin_in,
  output logic                         busy,
  output logic                         done,
  output logic [CHANNELS*DIGITS*4-1:0] bcd_out,
  output logic [CHANNELS-1:0]          ovf
);
  localparam int BCD_W = DIGITS * 4;
  localparam int SR_W  = BCD_W + BIN_WIDTH;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(BIN_WIDTH);

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam logic [31:0] LIMIT = 32'(pow10(DIGITS));

`ifdef BCD_SATURATE_EN
  localparam logic [BCD_W-1:0] OVF_FILL = {DIGITS{4'h9}};
`else
  localparam logic [BCD_W-1:0] OVF_FILL = '0;
`endif

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int d = 0; d < DIGITS; d++)
      if (t[BIN_WIDTH+4*d +: 4] >= 4'd5) t[BIN_WIDTH+4*d +: 4] = t[BIN_WIDTH+4*d +: 4] + 4'd3;
    return {t[SR_W-2:0], 1'b0};
  endfunction

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;

  state_t                        state;
  logic [CH_W-1:0]               ch;
  logic [CNT_W-1:0]              cnt;
  logic [SR_W-1:0]               sr;
  logic [CHANNELS*BIN_WIDTH-1:0] held;
  logic                          ovf_cur;
  logic [CHANNELS*BCD_W-1:0]     shadow_bcd, sh_bcd_nxt;
  logic [CHANNELS-1:0]           shadow_ovf, sh_ovf_nxt;
  logic [BIN_WIDTH-1:0]          cur;
  logic [BCD_W-1:0]              field;
  logic                          last_ch;

  assign cur     = held[ch*BIN_WIDTH +: BIN_WIDTH];
  assign field   = ovf_cur ? OVF_FILL : sr[SR_W-1:BIN_WIDTH];
  assign last_ch = (ch == CH_W'(CHANNELS - 1));

  // Shadow image including the channel being stored, so the final channel can
  // reach the outputs on the same edge it is written.
  always_comb begin
    sh_bcd_nxt = shadow_bcd;
    sh_ovf_nxt = shadow_ovf;
    sh_bcd_nxt[ch*BCD_W +: BCD_W] = field;
    sh_ovf_nxt[ch] = ovf_cur;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ch         <= '0;
      cnt        <= '0;
      sr         <= '0;
      held       <= '0;
      ovf_cur    <= 1'b0;
      shadow_bcd <= '0;
      shadow_ovf <= '0;
      bcd_out    <= '0;
      ovf        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          held  <= bin_in;
          ch    <= '0;
          busy  <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          sr      <= {{BCD_W{1'b0}}, cur};
          cnt     <= '0;
          ovf_cur <= (32'(cur) >= LIMIT);
          state   <= SHIFT;
        end
        SHIFT: begin
          sr  <= dabble(sr);
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_WIDTH - 1)) state <= STORE;
        end
        STORE: begin
          shadow_bcd <= sh_bcd_nxt;
          shadow_ovf <= sh_ovf_nxt;
          if (last_ch) begin
            bcd_out <= sh_bcd_nxt;
            ovf     <= sh_ovf_nxt;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            ch    <= ch + 1'b1;
            state <= LOAD;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
